// File: rtl/divisor_frecuencia_prog.sv
// Programmable clock divider: divide clk by N, glitch-free registered clk_out,
// one-cycle tick per period, divisor changes deferred to a period boundary.
//
// Ports:
//   clk      - system clock, all logic on posedge
//   reset_n  - asynchronous active-low reset
//   en       - count enable, 0 freezes the divider (loads still accepted)
//   div_load - strobe capturing div_val as the pending divisor
//   div_val  - new divisor N (0 stops, 1 ticks every cycle)
//   clk_out  - divided clock, high floor(N/2) of every N enabled cycles
//   tick     - high for the cycle following each terminal count
//   pending  - a loaded divisor is waiting for a period boundary
//   div_cur  - divisor currently in effect
module divisor_frecuencia_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic [WIDTH-1:0] div_cur
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend_val;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic             w_run;
  logic             w_term;
  logic             w_bound;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_pval_nxt;
  logic             w_pend_nxt;
  logic             w_clk_nxt;

  assign w_run  = en && (r_div != '0);
  assign w_term = w_run && (r_cnt == r_div - WIDTH'(1));

  // A stopped divider (N=0) has no period to finish, so every enabled
  // edge is a boundary where a new divisor may take over.
  assign w_bound = w_term || (en && (r_div == '0));

  always_comb begin
    w_div_nxt  = r_div;
    w_pend_nxt = r_pend;
    w_pval_nxt = r_pend_val;
    if (w_bound) begin
      w_pend_nxt = 1'b0;
      if (div_load) begin
        w_div_nxt = div_val;
      end else if (r_pend) begin
        w_div_nxt = r_pend_val;
      end
    end else if (div_load) begin
      w_pval_nxt = div_val;
      w_pend_nxt = 1'b1;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_term) begin
      w_cnt_nxt = '0;
    end else if (w_run) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
  end

  // Decode against the divisor that governs the coming cycle, so the
  // first period after a switch already has the new duty cycle.
  assign w_clk_nxt = (w_cnt_nxt < (w_div_nxt >> 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_div      <= WIDTH'(DEFAULT_DIV);
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_pend_val <= w_pval_nxt;
      r_pend     <= w_pend_nxt;
      r_tick     <= w_term;
      if (en) begin
        r_cnt <= w_cnt_nxt;
        r_div <= w_div_nxt;
        r_clk <= w_clk_nxt;
      end
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign pending = r_pend;
  assign div_cur = r_div;

endmodule
